// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_if: redirect, instruction-memory and decode-side signals of the fetch unit.
// PC_MISALIGN_TRAP_EN adds the misaligned-redirect trap outputs.
interface pc_fetch_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign_trap;
    logic [31:0] misalign_addr;
`endif
    modport master (
`ifdef PC_MISALIGN_TRAP_EN
        output misalign_trap, misalign_addr,
`endif
        input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
        output imem_req_valid, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4
    );
    modport slave (
`ifdef PC_MISALIGN_TRAP_EN
        input  misalign_trap, misalign_addr,
`endif
        output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
        input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the PC, issues single-outstanding imem reads and buffers words for decode.
// Optional PC_MISALIGN_TRAP_EN: misaligned redirect raises a sticky trap and halts fetching.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input logic        clk,
    input logic        reset,
    pc_fetch_if.master f
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d, addr_q, addr_d, tgt_pc;
    logic          discard_q, discard_d, halt_q, halt_d, bad_tgt;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [31:0]   pc_mem_q [FIFO_DEPTH];
    logic [31:0]   data_mem_q [FIFO_DEPTH];
    logic          rd, accept, resp, push, pop, space;
`ifdef PC_MISALIGN_TRAP_EN
    assign tgt_pc  = f.redirect_pc;
    assign bad_tgt = |f.redirect_pc[1:0];
`else
    assign tgt_pc  = f.redirect_pc & ~32'h3;
    assign bad_tgt = 1'b0;
`endif
    always_comb begin
        rd        = f.redirect_valid;
        accept    = state_q == REQ && f.imem_req_ready;
        resp      = state_q == WAIT && f.imem_resp_valid;
        push      = resp && !discard_q && !rd;
        pop       = f.instr_valid && f.instr_ready && !rd;
        cnt_d     = rd ? '0 : cnt_q + CW'(push) - CW'(pop);
        space     = cnt_d < CW'(FIFO_DEPTH);
        halt_d    = halt_q || (rd && bad_tgt);
        // a request accepted after a redirect is the stale one, so it must not advance the new pc
        pc_d      = rd ? tgt_pc : accept && !discard_q ? pc_q + 32'd4 : pc_q;
        discard_d = !halt_d && (state_q == IDLE ? discard_q :
                                state_q == REQ  ? (rd || discard_q) : (!resp && (rd || discard_q)));
        state_d   = halt_d ? IDLE :
                    state_q == IDLE ? (space ? REQ : IDLE) :
                    state_q == REQ  ? (accept ? WAIT : REQ) :
                    resp ? (space ? REQ : IDLE) : WAIT;
        addr_d    = state_d == REQ && state_q != REQ ? pc_d : addr_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            discard_q <= 1'b0;
            halt_q    <= 1'b0;
            cnt_q     <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            discard_q <= discard_d;
            halt_q    <= halt_d;
            cnt_q     <= cnt_d;
            if (rd) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) begin
                    pc_mem_q[wr_ptr_q]   <= addr_q;
                    data_mem_q[wr_ptr_q] <= f.imem_resp_data;
                    wr_ptr_q             <= wr_ptr_q + AW'(1);
                end
                if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end
`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f.misalign_trap <= 1'b0;
            f.misalign_addr <= '0;
        end else if (rd && bad_tgt && !halt_q) begin
            f.misalign_trap <= 1'b1;
            f.misalign_addr <= f.redirect_pc;
        end
    end
`endif
    assign f.imem_req_valid = state_q == REQ;
    assign f.imem_addr      = addr_q;
    assign f.instr_valid    = cnt_q != '0;
    assign f.instr          = data_mem_q[rd_ptr_q];
    assign f.instr_pc       = pc_mem_q[rd_ptr_q];
    assign f.instr_pc_plus4 = pc_mem_q[rd_ptr_q] + 32'd4;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: random memory/decode/redirect stimulus against an in-order PC-stream model,
// plus directed latency, buffering, redirect-timing and wrap cases.
module tb_pc_fetch_unit;
    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;
    pc_fetch_if b();
    pc_fetch_unit #(.RESET_PC(32'h100), .FIFO_DEPTH(2)) dut (.clk(clk), .reset(reset), .f(b));

    int total = 0, bad = 0;
    int p_ready, p_ir, p_redir, max_dly, redir_when, dly, pops;
    logic outstanding, prev_stall, fired, want_first, o_req, o_iv;
    logic [31:0] out_addr, prev_addr, exp_pc, first_pc, force_tgt, o_addr;
    logic [31:0] reqs_after[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        t = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) << 2)
                                        : 32'h1000 + 32'($urandom_range(0, 255) << 2);
`ifndef PC_MISALIGN_TRAP_EN
        t[1:0] = 2'($urandom_range(0, 3));
`endif
        return t;
    endfunction

    task automatic set_knobs(input int r, input int d, input int ir, input int rd);
        p_ready = r; max_dly = d; p_ir = ir; p_redir = rd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        b.redirect_valid = 0; b.redirect_pc = 0; b.imem_req_ready = 0;
        b.imem_resp_valid = 0; b.imem_resp_data = 0; b.instr_ready = 0;
        #1;
        chk("rst_req_valid", 32'(b.imem_req_valid), 32'd0);
        chk("rst_addr", b.imem_addr, 32'h100);
        chk("rst_instr_valid", 32'(b.instr_valid), 32'd0);
        chk("rst_instr", b.instr, 32'd0);
        chk("rst_instr_pc", b.instr_pc, 32'd0);
        chk("rst_pc_plus4", b.instr_pc_plus4, 32'd4);
`ifdef PC_MISALIGN_TRAP_EN
        chk("rst_trap", 32'(b.misalign_trap), 32'd0);
        chk("rst_trap_addr", b.misalign_addr, 32'd0);
`endif
        outstanding = 0; prev_stall = 0; dly = 0; redir_when = 0;
        exp_pc = 32'h100; want_first = 1; first_pc = 32'hDEAD_BEEF;
        reqs_after.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cycle();
        logic rdv, rdy, rsp, real_rsp, irdy, hold, is_bad;
        logic [31:0] tgt, ea, rdata;
        @(negedge clk);
        o_req = b.imem_req_valid; o_addr = b.imem_addr; o_iv = b.instr_valid;
        if (prev_stall) begin
            chk("req_hold_valid", 32'(o_req), 32'd1);
            chk("req_hold_addr", o_addr, prev_addr);
        end
        if (o_req) chk("one_outstanding", 32'(outstanding), 32'd0);
        chk("addr_align", 32'(o_addr[1:0]), 32'd0);
        hold = redir_when == 3 && outstanding;
        rsp = 0; real_rsp = 0; rdata = $urandom;
        if (outstanding && dly == 0 && !hold) begin
            rsp = 1; real_rsp = 1; rdata = mem_word(out_addr);
        end else if (!outstanding && $urandom_range(0, 99) < 10) rsp = 1;
        else if (outstanding && dly != 0) dly--;
        rdy  = $urandom_range(0, 99) < p_ready;
        irdy = $urandom_range(0, 99) < p_ir;
        rdv  = $urandom_range(0, 99) < p_redir;
        tgt  = rand_tgt();
        if ((redir_when == 1 && o_req) || (redir_when == 2 && real_rsp) || (redir_when == 3 && hold) ||
            (redir_when == 4 && o_req)) begin
            rdv = 1; tgt = force_tgt; fired = 1;
            if (redir_when == 4) rdy = 0;
            redir_when = 0;
        end
`ifdef PC_MISALIGN_TRAP_EN
        ea = tgt; is_bad = rdv && tgt[1:0] != 2'b00;
`else
        ea = tgt & ~32'h3; is_bad = 0;
`endif
        b.redirect_valid = rdv; b.redirect_pc = tgt; b.imem_req_ready = rdy;
        b.imem_resp_valid = rsp; b.imem_resp_data = rdata; b.instr_ready = irdy;
        if (o_req && rdy) reqs_after.push_back(o_addr);
        if (rdv) begin
            exp_pc = ea; want_first = 1; first_pc = 32'hDEAD_BEEF;
            reqs_after.delete();
        end else if (o_iv && irdy) begin
            chk("dec_pc", b.instr_pc, exp_pc);
            chk("dec_instr", b.instr, mem_word(exp_pc));
            chk("dec_pc_plus4", b.instr_pc_plus4, exp_pc + 32'd4);
            if (want_first) begin first_pc = b.instr_pc; want_first = 0; end
            exp_pc += 32'd4;
            pops++;
        end
        if (real_rsp) outstanding = 0;
        if (o_req && rdy) begin
            outstanding = 1; out_addr = o_addr; dly = $urandom_range(0, max_dly);
        end
        prev_stall = o_req && !rdy && !is_bad;
        prev_addr = o_addr;
    endtask

    task automatic redir_test(input int mode, input logic [31:0] tgt, input logic [31:0] req0,
                              input logic [31:0] req1, input logic [31:0] pc0);
        do_reset();
        set_knobs(100, 0, 100, 0);
        repeat (4) cycle();
        redir_when = mode; force_tgt = tgt; fired = 0;
        repeat (16) cycle();
        chk($sformatf("m%0d_fired", mode), 32'(fired), 32'd1);
        chk($sformatf("m%0d_req0", mode), reqs_after.size() > 0 ? reqs_after[0] : 32'hDEAD_BEEF, req0);
        chk($sformatf("m%0d_req1", mode), reqs_after.size() > 1 ? reqs_after[1] : 32'hDEAD_BEEF, req1);
        chk($sformatf("m%0d_first_pc", mode), first_pc, pc0);
    endtask

    initial begin
        int n, p0;
        pops = 0;
        do_reset();
        set_knobs(100, 0, 100, 0);
        cycle();
        chk("lat_c1_req", 32'(o_req), 32'd1);
        chk("lat_c1_addr", o_addr, 32'h100);
        chk("lat_c1_iv", 32'(o_iv), 32'd0);
        cycle();
        chk("lat_c2_req", 32'(o_req), 32'd0);
        chk("lat_c2_iv", 32'(o_iv), 32'd0);
        cycle();
        chk("lat_c3_iv", 32'(o_iv), 32'd1);
        repeat (8) cycle();
        chk("seq_req0", reqs_after.size() > 0 ? reqs_after[0] : 32'hDEAD_BEEF, 32'h100);
        chk("seq_req1", reqs_after.size() > 1 ? reqs_after[1] : 32'hDEAD_BEEF, 32'h104);
        chk("seq_req2", reqs_after.size() > 2 ? reqs_after[2] : 32'hDEAD_BEEF, 32'h108);
        chk("seq_first_pc", first_pc, 32'h100);

        do_reset();
        set_knobs(100, 0, 0, 0);
        repeat (10) cycle();
        chk("stall_iv", 32'(o_iv), 32'd1);
        chk("stall_req", 32'(o_req), 32'd0);
        set_knobs(0, 0, 100, 0);
        p0 = pops;
        repeat (6) cycle();
        chk("stall_buffered", 32'(pops - p0), 32'd2);
        chk("stall_first_pc", first_pc, 32'h100);

        redir_test(3, 32'h200, 32'h200, 32'h204, 32'h200);
        redir_test(2, 32'h300, 32'h300, 32'h304, 32'h300);
        redir_test(1, 32'h400, 32'h400, 32'h404, 32'h400);
        redir_test(4, 32'h500, 32'h108, 32'h500, 32'h500);
        redir_test(2, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC);
`ifndef PC_MISALIGN_TRAP_EN
        redir_test(2, 32'h202, 32'h200, 32'h204, 32'h200);
`endif

        do_reset();
        set_knobs(70, 2, 60, 4);
        p0 = pops;
        repeat (1500) cycle();
        do_reset();
        set_knobs(70, 2, 60, 4);
        repeat (1500) cycle();
        chk("random_progress", 32'(pops - p0 > 100), 32'd1);

`ifdef PC_MISALIGN_TRAP_EN
        do_reset();
        set_knobs(100, 0, 100, 0);
        repeat (4) cycle();
        redir_when = 2; force_tgt = 32'h202; fired = 0;
        repeat (3) cycle();
        chk("trap_fired", 32'(fired), 32'd1);
        chk("trap_flag", 32'(b.misalign_trap), 32'd1);
        chk("trap_addr", b.misalign_addr, 32'h202);
        n = 0;
        repeat (10) begin
            cycle();
            n += int'(o_req);
        end
        chk("trap_no_req", 32'(n), 32'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
